fp_to_int_fsm: RTL and testbench

FP_TO_INT_FSM -- requirements
Module: fp_to_int_fsm

---
 rtl/fp_to_int_fsm.sv | 158 +++++++++++++++
 tb/tb_fp_to_int_fsm.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/fp_to_int_fsm.sv
// fp_to_int_fsm: multi-cycle IEEE-754 single-precision to int32 converter.
// One operand is accepted in IDLE. It passes through UNPACK, SHIFT and PACK,
// and the result is presented with a one-cycle r_o pulse in DONE.
// Fractions truncate toward zero. Out-of-range values saturate, and NaN maps
// to the int32 minimum with ovf set.
module fp_to_int_fsm (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        r_i,
  input  logic [31:0] a,
  output logic [31:0] res,
  output logic        r_o,
  output logic        ovf
);

  typedef enum logic [2:0] {IDLE, UNPACK, SHIFT, PACK, DONE} state_t;
  typedef enum logic [1:0] {CLS_ZERO, CLS_NORM, CLS_SAT, CLS_NAN} cls_t;

  state_t      state_r;
  state_t      state_s;
  logic [31:0] op_r;
  logic        s_r;
  logic [7:0]  e_r;
  logic [23:0] m_r;
  cls_t        cls_r;
  logic        min_r;
  logic [31:0] mag_r;
  logic [32:0] pack_s;

  // Operand class from the biased exponent and the mantissa.
  function automatic cls_t classify(input logic [31:0] op);
    cls_t c;
    if (op[30:23] < 8'd127) begin
      c = CLS_ZERO;
    end else if (op[30:23] <= 8'd157) begin
      c = CLS_NORM;
    end else if ((op[30:23] == 8'd255) && (op[22:0] != 23'd0)) begin
      c = CLS_NAN;
    end else begin
      c = CLS_SAT;
    end
    return c;
  endfunction

  // Align the 24-bit significand to the integer point (the exponent bias
  // plus 23 fraction bits gives 150). Bits shifted out on the right are
  // dropped, so the result truncates toward zero.
  function automatic logic [31:0] shift_mag(input logic [23:0] m, input logic [7:0] e);
    logic [31:0] wide;
    wide = {8'd0, m};
    if (e >= 8'd150) begin
      return wide << (e - 8'd150);
    end else begin
      return wide >> (8'd150 - e);
    end
  endfunction

  // Final {ovf, res} from the class, sign and magnitude. The exact value
  // -2^31 is representable, so it is the one saturating case without ovf.
  function automatic logic [32:0] pack_res(input cls_t c, input logic s,
                                           input logic [31:0] mag, input logic is_min);
    logic [32:0] r;
    case (c)
      CLS_ZERO: r = {1'b0, 32'h0000_0000};
      CLS_NORM: r = {1'b0, (s ? (~mag + 32'd1) : mag)};
      CLS_SAT:  r = s ? {~is_min, 32'h8000_0000} : {1'b1, 32'h7FFF_FFFF};
      CLS_NAN:  r = {1'b1, 32'h8000_0000};
      default:  r = {1'b1, 32'h8000_0000};
    endcase
    return r;
  endfunction

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic: a fixed five-state loop, with acceptance only in IDLE.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (r_i) begin
          state_s = UNPACK;
        end else begin
          state_s = IDLE;
        end
      end
      UNPACK:  state_s = SHIFT;
      SHIFT:   state_s = PACK;
      PACK:    state_s = DONE;
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Packed result of the current conversion, consumed in PACK.
  always_comb begin
    pack_s = pack_res(cls_r, s_r, mag_r, min_r);
  end

  // Datapath: each pipeline stage loads its registers in its own state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_r  <= 32'd0;
      s_r   <= 1'b0;
      e_r   <= 8'd0;
      m_r   <= 24'd0;
      cls_r <= CLS_ZERO;
      min_r <= 1'b0;
      mag_r <= 32'd0;
      res   <= 32'd0;
      ovf   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (r_i) begin
            op_r <= a;
          end
        end
        UNPACK: begin
          s_r   <= op_r[31];
          e_r   <= op_r[30:23];
          m_r   <= {1'b1, op_r[22:0]};
          cls_r <= classify(op_r);
          min_r <= (op_r == 32'hCF00_0000);
        end
        SHIFT: begin
          mag_r <= shift_mag(m_r, e_r);
        end
        PACK: begin
          res <= pack_s[31:0];
          ovf <= pack_s[32];
        end
        DONE: begin
          op_r <= op_r;
        end
        default: begin
          op_r <= op_r;
        end
      endcase
    end
  end

  // Result-ready pulse: high for exactly the DONE cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_o <= 1'b0;
    end else begin
      r_o <= (state_r == PACK);
    end
  end

endmodule

// File: tb/tb_fp_to_int_fsm.sv
// Self-checking bench for fp_to_int_fsm. Expected results are pushed to a
// scoreboard when a request is driven. A monitor pops and compares them
// (value, ovf and arrival cycle) whenever the DUT raises r_o.
module tb_fp_to_int_fsm;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        r_i;
  logic [31:0] a;
  logic [31:0] res;
  logic        r_o;
  logic        ovf;

  typedef struct {
    logic [31:0] res;
    logic        ovf;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   passed = 0;
  int   total = 0;

  fp_to_int_fsm dut (
    .clk   (clk),
    .rst_n (rst_n),
    .r_i   (r_i),
    .a     (a),
    .res   (res),
    .r_o   (r_o),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  // Edge counter.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s: got %h expected %h", tag, obs, expv);
  endtask

  // Monitor: every r_o pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && r_o === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_r_o", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("res", res, e.res);
        check("ovf", {31'd0, ovf}, {31'd0, e.ovf});
        check("latency_cycle", cyc, e.due);
      end
    end
  end

  // Push the expectation for a request sampled at the coming edge; r_o is
  // due at the negedge after three more edges.
  task automatic expect_at_next_edge(input logic [31:0] er, input logic eo);
    exp_t e;
    e.res = er;
    e.ovf = eo;
    e.due = cyc + 4;
    sb.push_back(e);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
    check("drain", sb.size(), 32'd0);
    @(negedge clk);
  endtask

  // One isolated conversion; a is scrambled after acceptance.
  task automatic convert(input logic [31:0] val, input logic [31:0] er, input logic eo);
    @(negedge clk);
    r_i = 1'b1;
    a = val;
    expect_at_next_edge(er, eo);
    @(negedge clk);
    r_i = 1'b0;
    a = $urandom;
    wait_drain();
  endtask

  logic [31:0] stream [0:10];

  initial begin
    rst_n = 1'b0;
    r_i = 1'b0;
    a = 32'd0;
    repeat (2) @(negedge clk);
    check("reset_res", res, 32'd0);
    check("reset_ovf", {31'd0, ovf}, 32'd0);
    check("reset_r_o", {31'd0, r_o}, 32'd0);
    rst_n = 1'b1;

    convert(32'h3FC0_0000, 32'h0000_0001, 1'b0);
    convert(32'hC2F6_E979, 32'hFFFF_FF85, 1'b0);
    convert(32'h3F00_0000, 32'h0000_0000, 1'b0);
    convert(32'h4F00_0000, 32'h7FFF_FFFF, 1'b1);
    convert(32'hCF00_0000, 32'h8000_0000, 1'b0);
    convert(32'hFF80_0000, 32'h8000_0000, 1'b1);
    convert(32'h7FC0_0000, 32'h8000_0000, 1'b1);
    convert(32'h0000_0001, 32'h0000_0000, 1'b0);
    convert(32'h4EFF_FFFF, 32'h7FFF_FF80, 1'b0);
    convert(32'hCF00_0001, 32'h8000_0000, 1'b1);
    convert(32'h7F80_0000, 32'h7FFF_FFFF, 1'b1);
    convert(32'hFFC0_0000, 32'h8000_0000, 1'b1);
    convert(32'h3F7F_FFFF, 32'h0000_0000, 1'b0);
    convert(32'h4B00_0001, 32'h0080_0001, 1'b0);
    convert(32'h3F80_0000, 32'h0000_0001, 1'b0);

    // The result holds until the next conversion.
    repeat (3) @(negedge clk);
    check("hold_res", res, 32'h0000_0001);

    // r_i held high with a changing every cycle: accepts at N, N+5, N+10.
    for (int k = 0; k <= 10; k++) stream[k] = 32'h7FC0_0000 ^ k;
    stream[0]  = 32'h3F80_0000;
    stream[5]  = 32'hC040_0000;
    stream[10] = 32'h42C8_0000;
    @(negedge clk);
    r_i = 1'b1;
    for (int k = 0; k <= 10; k++) begin
      if (k != 0) @(negedge clk);
      a = stream[k];
      if (k == 0)  expect_at_next_edge(32'h0000_0001, 1'b0);
      if (k == 5)  expect_at_next_edge(32'hFFFF_FFFD, 1'b0);
      if (k == 10) expect_at_next_edge(32'h0000_0064, 1'b0);
    end
    @(negedge clk);
    r_i = 1'b0;
    wait_drain();

    // Reset during SHIFT aborts the conversion.
    @(negedge clk);
    r_i = 1'b1;
    a = 32'h4120_0000;
    @(negedge clk);
    r_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_res", res, 32'd0);
    check("abort_ovf", {31'd0, ovf}, 32'd0);
    check("abort_r_o", {31'd0, r_o}, 32'd0);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("abort_res_after", res, 32'd0);
    convert(32'h4120_0000, 32'h0000_000A, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
